// File: rtl/pkt_out_arb.sv
// pkt_out_arb: two-source packet arbiter feeding one byte-wide output port.
//
// Source 0 (header path) and source 1 (packet-data path) request the output
// with req0/req1. A grant lasts for one whole packet. It ends on the byte that
// carries ctl == 8'hFF, or it is force-released by a watchdog after MAX_BYTES
// bytes. When both sources request together, the source that was not served
// last wins. The granted stream reaches out_* through one register stage.
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   req0/req1                    output-port requests
//   in_valid*/in_ctl*/in_data*   byte streams from each source
//   gnt0/gnt1                    registered grants (at most one high)
//   out_valid/out_ctl/out_data   merged stream, 1-cycle latency, zero when idle
//   pkt_cnt0/pkt_cnt1            completed-packet counters (wrap silently)
//   timeout_err                  sticky watchdog flag, cleared only by reset
module pkt_out_arb #(
  parameter int unsigned MAX_BYTES = 60,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             in_valid0,
  input  logic             in_valid1,
  input  logic [7:0]       in_ctl0,
  input  logic [7:0]       in_ctl1,
  input  logic [7:0]       in_data0,
  input  logic [7:0]       in_data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_valid,
  output logic [7:0]       out_ctl,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             timeout_err
);

  localparam int unsigned BcW = $clog2(MAX_BYTES + 1);
  // Counter value just before the byte that reaches the watchdog limit.
  localparam logic [BcW-1:0] LastIdx = BcW'(MAX_BYTES - 1);
  localparam logic [7:0] LastCtl = 8'hFF;

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e           state_q, state_d;
  logic [BcW-1:0]   byte_cnt_q, byte_cnt_d;
  // High when source 1 wins a simultaneous request (source 0 was served last).
  logic             prio1_q, prio1_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_ctl_q, out_ctl_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic             timeout_q, timeout_d;

  // Byte stream of the currently granted source; the other source is never looked at.
  logic       sel_valid;
  logic [7:0] sel_ctl;
  logic [7:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_ctl   = 8'h00;
    sel_data  = 8'h00;
    if (state_q == StGrant0) begin
      sel_valid = in_valid0;
      sel_ctl   = in_ctl0;
      sel_data  = in_data0;
    end else if (state_q == StGrant1) begin
      sel_valid = in_valid1;
      sel_ctl   = in_ctl1;
      sel_data  = in_data1;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    prio1_d     = prio1_q;
    pkt_cnt0_d  = pkt_cnt0_q;
    pkt_cnt1_d  = pkt_cnt1_q;
    timeout_d   = timeout_q;
    out_valid_d = 1'b0;
    out_ctl_d   = 8'h00;
    out_data_d  = 8'h00;

    unique case (state_q)
      StIdle: begin
        byte_cnt_d = '0;
        if (req0 && req1) begin
          state_d = prio1_q ? StGrant1 : StGrant0;
        end else if (req0) begin
          state_d = StGrant0;
        end else if (req1) begin
          state_d = StGrant1;
        end
      end

      StGrant0, StGrant1: begin
        // req is deliberately ignored here: only the marker or the watchdog ends a grant.
        if (sel_valid) begin
          out_valid_d = 1'b1;
          out_ctl_d   = sel_ctl;
          out_data_d  = sel_data;
          byte_cnt_d  = byte_cnt_q + BcW'(1);
          // The end marker takes precedence over the watchdog on the same byte.
          if (sel_ctl == LastCtl) begin
            state_d = StIdle;
            prio1_d = (state_q == StGrant0);
            if (state_q == StGrant0) begin
              pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
            end else begin
              pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
            end
          end else if (byte_cnt_q == LastIdx) begin
            state_d   = StIdle;
            prio1_d   = (state_q == StGrant0);
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Grants come from the next state, so they are high exactly while in GRANTN.
    gnt0_d = (state_d == StGrant0);
    gnt1_d = (state_d == StGrant1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      prio1_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ctl_q   <= 8'h00;
      out_data_q  <= 8'h00;
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      prio1_q     <= prio1_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      out_valid_q <= out_valid_d;
      out_ctl_q   <= out_ctl_d;
      out_data_q  <= out_data_d;
      pkt_cnt0_q  <= pkt_cnt0_d;
      pkt_cnt1_q  <= pkt_cnt1_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign out_valid   = out_valid_q;
  assign out_ctl     = out_ctl_q;
  assign out_data    = out_data_q;
  assign pkt_cnt0    = pkt_cnt0_q;
  assign pkt_cnt1    = pkt_cnt1_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pkt_out_arb.sv
// Directed bench for pkt_out_arb. Inputs change and outputs are checked on the
// falling clock edge, midway between the rising edges where the DUT samples.
module tb_pkt_out_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic        in_valid0, in_valid1;
  logic [7:0]  in_ctl0, in_ctl1, in_data0, in_data1;
  logic        gnt0, gnt1, out_valid, timeout_err;
  logic [7:0]  out_ctl, out_data;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pkt_out_arb #(
    .MAX_BYTES(60),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .in_valid0  (in_valid0),
    .in_valid1  (in_valid1),
    .in_ctl0    (in_ctl0),
    .in_ctl1    (in_ctl1),
    .in_data0   (in_data0),
    .in_data1   (in_data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .out_valid  (out_valid),
    .out_ctl    (out_ctl),
    .out_data   (out_data),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; req1 = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_ctl0 = 8'h00; in_ctl1 = 8'h00;
    in_data0 = 8'h00; in_data1 = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a grant; the grant must appear exactly one cycle later.
  task automatic wait_gnt(input int exp_src, input string tag);
    int idle = 0;
    while (!(gnt0 || gnt1) && idle < 10) begin
      idle++;
      @(negedge clk);
    end
    check({tag, "_gap"}, idle, 1);
    check({tag, "_gnt0"}, gnt0, (exp_src == 0) ? 1 : 0);
    check({tag, "_gnt1"}, gnt1, (exp_src == 1) ? 1 : 0);
  endtask

  // Sends n bytes from src while the other source streams noise (valid toggling,
  // ctl=FF), and checks each byte one cycle later on out_*.
  task automatic send_pkt(input int src, input int n, input bit ff_last, input int base);
    logic [7:0] d, c;
    for (int i = 0; i < n; i++) begin
      d = 8'(base + i);
      c = (ff_last && i == n - 1) ? 8'hFF : 8'(i & 15);
      if (src == 0) begin
        in_valid0 = 1'b1; in_data0 = d; in_ctl0 = c;
        in_valid1 = i[0]; in_data1 = 8'hA5 ^ 8'(i); in_ctl1 = 8'hFF;
      end else begin
        in_valid1 = 1'b1; in_data1 = d; in_ctl1 = c;
        in_valid0 = i[0]; in_data0 = 8'h5A ^ 8'(i); in_ctl0 = 8'hFF;
      end
      @(negedge clk);
      check("byte_valid", out_valid, 1);
      check("byte_data", out_data, d);
      check("byte_ctl", out_ctl, c);
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset state
    do_reset();
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ctl", out_ctl, 0);
    check("rst_data", out_data, 0);
    check("rst_cnt0", pkt_cnt0, 0);
    check("rst_cnt1", pkt_cnt1, 0);
    check("rst_tmo", timeout_err, 0);

    // Single source, 60-byte packet with the marker on the last byte
    req0 = 1'b1;
    wait_gnt(0, "single");
    in_valid0 = 1'b0; in_data0 = 8'h77; in_ctl0 = 8'h55;
    @(negedge clk);
    check("nv_valid", out_valid, 0);
    check("nv_data", out_data, 0);
    check("nv_ctl", out_ctl, 0);
    send_pkt(0, 60, 1'b1, 0);
    req0 = 1'b0;
    check("single_end_gnt0", gnt0, 0);
    check("single_cnt0", pkt_cnt0, 1);
    check("single_tmo", timeout_err, 0);

    // Contention: round-robin 0,1,0,1,0,1
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(k % 2, "rr");
      send_pkt(k % 2, 3 + k, 1'b1, 16 * k);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_cnt0", pkt_cnt0, 3);
    check("rr_cnt1", pkt_cnt1, 3);
    check("rr_tmo", timeout_err, 0);

    // Watchdog: source 1 sends 60 bytes without a marker
    do_reset();
    req1 = 1'b1;
    wait_gnt(1, "wd");
    send_pkt(1, 60, 1'b0, 8'h40);
    check("wd_gnt1", gnt1, 0);
    check("wd_tmo", timeout_err, 1);
    check("wd_cnt1", pkt_cnt1, 0);
    req0 = 1'b1;
    wait_gnt(0, "wd_next");
    check("wd_tmo_sticky", timeout_err, 1);

    // Boundary: marker on the 60th byte; req dropped mid-grant
    do_reset();
    req1 = 1'b1;
    wait_gnt(1, "bd");
    req1 = 1'b0;
    send_pkt(1, 60, 1'b1, 8'h80);
    check("bd_gnt1", gnt1, 0);
    check("bd_cnt1", pkt_cnt1, 1);
    check("bd_tmo", timeout_err, 0);

    // Isolation then reset on byte 10
    do_reset();
    req0 = 1'b1;
    wait_gnt(0, "iso");
    send_pkt(0, 9, 1'b0, 8'hC0);
    in_valid0 = 1'b1; in_data0 = 8'hC9; in_ctl0 = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    check("mrst_gnt0", gnt0, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_ctl", out_ctl, 0);
    check("mrst_cnt0", pkt_cnt0, 0);
    reset = 1'b0;
    req0 = 1'b0;
    in_valid0 = 1'b0;
    @(negedge clk);
    check("post_rst_idle", gnt0, 0);
    check("post_rst_cnt0", pkt_cnt0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_out_arb.md
PKT_OUT_ARB -- requirements
Module: pkt_out_arb

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 60, maximum bytes per grant (one 480-bit word).
REQ-002 SHALL have parameter CNT_W, default 16, width of per-source packet counters.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0 / req1  input  1  source 0 (header path) / source 1 (packet-data path) requests the output port.
REQ-006 SHALL have ports in_valid0 / in_valid1  input  1  byte valid from each source.
REQ-007 SHALL have ports in_ctl0 / in_ctl1  input  8  per-byte control; 8'hFF marks the last byte of a packet.
REQ-008 SHALL have ports in_data0 / in_data1  input  8  byte data from each source.
REQ-009 SHALL have ports gnt0 / gnt1  output  1  grant to each source; at most one high.
REQ-010 SHALL have port out_valid  output  1  merged byte valid.
REQ-011 SHALL have port out_ctl  output  8  merged control.
REQ-012 SHALL have port out_data  output  8  merged data.
REQ-013 SHALL have ports pkt_cnt0 / pkt_cnt1  output  CNT_W  completed-packet count per source.
REQ-014 SHALL have port timeout_err  output  1  sticky flag: a grant was force-released by the watchdog.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-016 In IDLE, with exactly one req high, SHALL move to that source's GRANT state the next cycle.
REQ-017 In IDLE, with both req high, SHALL grant the source not served last (round-robin pointer); after reset the pointer favours source 0.
REQ-018 gntN SHALL be a registered output, high exactly while in GRANTN.
REQ-019 In GRANTN, SHALL pass in_validN/in_ctlN/in_dataN of the granted source through one register stage to out_*; latency is exactly 1 cycle.
REQ-020 SHALL ignore the non-granted source's valid/ctl/data completely.
REQ-021 When not in a GRANT state, or the granted source's in_valid is low, out_valid SHALL be 0, and out_ctl and out_data SHALL be 8'h00.
REQ-022 SHALL keep a byte counter, cleared on entry to GRANTN, incremented on each accepted byte (in_validN high while gntN high).
REQ-023 On an accepted byte with in_ctlN==8'hFF, SHALL increment pkt_cntN, update the round-robin pointer to N, and return to IDLE the next cycle (gntN low).
REQ-024 A new grant SHALL NOT be issued in the same cycle that the previous one ends; there is at least one IDLE cycle between grants.
REQ-025 If the byte counter reaches MAX_BYTES without a last-byte marker, SHALL force the FSM to IDLE, set timeout_err, update the pointer to N, and leave pkt_cntN unchanged.
REQ-026 If the last-byte marker and the watchdog limit occur on the same byte, SHALL treat the byte as a normal packet end: increment the count and do not set timeout_err.
REQ-027 A source dropping reqN mid-grant SHALL NOT end the grant; only the last-byte marker or the watchdog ends it.
REQ-028 pkt_cntN SHALL wrap modulo 2^CNT_W without a flag.
REQ-029 timeout_err SHALL remain set until reset.

Reset
REQ-030 While reset is high at a clock edge, SHALL set FSM=IDLE, gnt0=gnt1=0, out_valid=0, out_ctl=out_data=8'h00, byte counter=0, pkt_cnt0=pkt_cnt1=0, timeout_err=0, pointer favouring source 0.
REQ-031 Reset asserted mid-packet SHALL abort the grant with no count update; the first cycle after reset deasserts SHALL be IDLE.

Verification
REQ-032 Single source: req0=1, 60 bytes 0x00..0x3B, last byte ctl=FF -> gnt0 one cycle after req0; out_data mirrors input 1 cycle later; pkt_cnt0=1; timeout_err=0.
REQ-033 Contention: req0=req1=1 after reset, each sends 3 packets -> grant order 0,1,0,1,0,1; at least one IDLE cycle between grants; pkt_cnt0=pkt_cnt1=3.
REQ-034 Watchdog: source 1 sends 60 bytes with no FF marker -> forced to IDLE after byte 60; timeout_err=1; pkt_cnt1=0; next contention grants source 0.
REQ-035 Boundary: FF marker on the 60th byte -> pkt_cnt incremented; timeout_err stays 0.
REQ-036 Isolation and reset: source 0 granted, source 1 toggles valid/data -> out_* shows only source 0 bytes; reset asserted on byte 10 -> all outputs zero next cycle, pkt_cnt0 unchanged from 0.
